// File: rtl/dma_streamer.sv
// Turns one DMA descriptor into a train of AXI-legal burst requests.
// Bursts are capped by the beat limit and never cross a 4 KB page.
module dma_streamer #(
  parameter int unsigned STREAM_TYPE    = 0,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned MAX_BEAT_BURST = 256,
  parameter int unsigned MAX_BURST_EN   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dma_go_i,
  input  logic                    dma_abort_i,
  input  logic [31:0]             desc_src_addr_i,
  input  logic [31:0]             desc_dst_addr_i,
  input  logic [31:0]             desc_num_bytes_i,
  output logic [31:0]             req_addr_o,
  output logic [7:0]              req_alen_o,
  output logic [2:0]              req_size_o,
  output logic [DATA_WIDTH/8-1:0] req_strb_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic                    done_o,
  output logic                    err_valid_o,
  output logic [31:0]             err_addr_o,
  output logic [1:0]              err_src_o
);

  localparam int unsigned Bpb             = DATA_WIDTH / 8;
  localparam int unsigned OffW            = $clog2(Bpb);
  localparam logic [31:0] OffMask         = 32'(Bpb - 1);
  localparam logic [32:0] BurstCap        = (MAX_BURST_EN != 0) ? 33'(MAX_BEAT_BURST) : 33'd1;
  localparam logic [1:0]  DmaUnalignedErr = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StDone} dma_st_t;

  dma_st_t     st_q, st_d;
  logic [31:0] addr_q, addr_d;
  logic [32:0] rem_q, rem_d;
  logic        abort_q, abort_d;
  logic        err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [31:0] go_addr;
  logic [12:0] to_4k;
  logic [32:0] b4k;
  logic [32:0] beats;
  logic [31:0] step;

  always_comb begin
    go_addr = (STREAM_TYPE != 0) ? desc_dst_addr_i : desc_src_addr_i;
    // An aligned page start yields 4096 bytes, hence the 13-bit width.
    to_4k   = 13'd4096 - {1'b0, addr_q[11:0]};
    b4k     = {20'd0, to_4k} >> OffW;
    beats   = rem_q;
    if (b4k < beats) beats = b4k;
    if (BurstCap < beats) beats = BurstCap;
    step    = 32'(beats << OffW);
  end

  always_comb begin
    st_d        = st_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    abort_d     = abort_q;
    err_valid_d = 1'b0;
    err_addr_d  = err_addr_q;
    case (st_q)
      StIdle: begin
        if (dma_go_i) begin
          addr_d  = go_addr;
          rem_d   = {1'b0, desc_num_bytes_i} >> OffW;
          abort_d = 1'b0;
          if (desc_num_bytes_i == '0) begin
            st_d = StDone;
          end else if (((go_addr & OffMask) != '0) || ((desc_num_bytes_i & OffMask) != '0)) begin
            st_d        = StDone;
            err_valid_d = 1'b1;
            err_addr_d  = go_addr;
          end else begin
            st_d = StRun;
          end
        end
      end
      StRun: begin
        if (dma_abort_i) abort_d = 1'b1;
        if (req_ready_i) begin
          addr_d = addr_q + step;
          rem_d  = rem_q - beats;
          // An abort seen in the handshake cycle still lets this burst go out.
          if ((rem_d == '0) || abort_q || dma_abort_i) st_d = StDone;
        end
      end
      StDone: begin
        st_d    = StIdle;
        abort_d = 1'b0;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      abort_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      st_q        <= st_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      abort_q     <= abort_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    req_valid_o = (st_q == StRun);
    req_addr_o  = req_valid_o ? addr_q : '0;
    req_alen_o  = req_valid_o ? 8'(beats - 33'd1) : '0;
    req_size_o  = req_valid_o ? 3'(OffW) : '0;
    req_strb_o  = req_valid_o ? '1 : '0;
    done_o      = (st_q == StDone);
    err_valid_o = err_valid_q;
    err_addr_o  = err_addr_q;
    err_src_o   = err_valid_q ? DmaUnalignedErr : 2'd0;
  end

endmodule

// File: tb/tb_dma_streamer.sv
// Bench for dma_streamer: read, write and single-beat write instances driven in lockstep,
// each checked against a queue of expected bursts built from the splitting rules.
module tb_dma_streamer;

  localparam int NDut = 3;
  localparam int Bpb  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, go, abort, ready;
  logic [31:0] src, dst, nbytes;

  logic [31:0] req_addr  [NDut];
  logic [7:0]  req_alen  [NDut];
  logic [2:0]  req_size  [NDut];
  logic [7:0]  req_strb  [NDut];
  logic        req_valid [NDut];
  logic        done      [NDut];
  logic        err_valid [NDut];
  logic [31:0] err_addr  [NDut];
  logic [1:0]  err_src   [NDut];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    dma_streamer #(
      .STREAM_TYPE    ((g == 0) ? 0 : 1),
      .DATA_WIDTH     (64),
      .MAX_BEAT_BURST (256),
      .MAX_BURST_EN   ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .dma_go_i         (go),
      .dma_abort_i      (abort),
      .desc_src_addr_i  (src),
      .desc_dst_addr_i  (dst),
      .desc_num_bytes_i (nbytes),
      .req_addr_o       (req_addr[g]),
      .req_alen_o       (req_alen[g]),
      .req_size_o       (req_size[g]),
      .req_strb_o       (req_strb[g]),
      .req_valid_o      (req_valid[g]),
      .req_ready_i      (ready),
      .done_o           (done[g]),
      .err_valid_o      (err_valid[g]),
      .err_addr_o       (err_addr[g]),
      .err_src_o        (err_src[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one entry per instance.
  logic [31:0] exp_addr [NDut][$];
  logic [7:0]  exp_alen [NDut][$];
  bit          exp_err       [NDut];
  bit          exp_done_next [NDut];
  bit          finished      [NDut];
  logic [31:0] exp_err_addr  [NDut];
  int unsigned max_beats     [NDut] = '{256, 256, 1};

  task automatic build(input int k, input logic [31:0] a, input logic [31:0] nb);
    longint unsigned rem, lim, b;
    logic [31:0] p;
    exp_addr[k].delete();
    exp_alen[k].delete();
    exp_err[k]      = 1'b0;
    exp_err_addr[k] = a;
    p               = a;
    if (nb != 0 && ((a % Bpb) != 0 || (nb % Bpb) != 0)) begin
      exp_err[k] = 1'b1;
    end else begin
      rem = nb / Bpb;
      while (rem > 0) begin
        lim = (4096 - (p % 4096)) / Bpb;
        b   = rem;
        if (lim < b) b = lim;
        if (max_beats[k] < b) b = max_beats[k];
        exp_addr[k].push_back(p);
        exp_alen[k].push_back(8'(b - 1));
        p   = p + 32'(b * Bpb);
        rem = rem - b;
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int k = 0; k < NDut; k++) begin
      check_eq($sformatf("%s_d%0d_valid", tag, k), req_valid[k], 0);
      check_eq($sformatf("%s_d%0d_addr", tag, k), req_addr[k], 0);
      check_eq($sformatf("%s_d%0d_alen", tag, k), req_alen[k], 0);
      check_eq($sformatf("%s_d%0d_size", tag, k), req_size[k], 0);
      check_eq($sformatf("%s_d%0d_strb", tag, k), req_strb[k], 0);
      check_eq($sformatf("%s_d%0d_done", tag, k), done[k], 0);
      check_eq($sformatf("%s_d%0d_errv", tag, k), err_valid[k], 0);
      check_eq($sformatf("%s_d%0d_erra", tag, k), err_addr[k], 0);
      check_eq($sformatf("%s_d%0d_errs", tag, k), err_src[k], 0);
    end
  endtask

  // mode 0: ready high; 1: random ready plus a stray go mid-run; 2: ready low for 5 cycles.
  task automatic run_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] nb,
                          input int mode, input bit do_abort, input bit go_abort);
    int cyc;
    bit all_fin;
    bit exp_v;
    bit stray_ok;
    for (int k = 0; k < NDut; k++) begin
      build(k, (k == 0) ? s : d, nb);
      finished[k]      = 1'b0;
      exp_done_next[k] = (exp_addr[k].size() == 0);
    end
    @(negedge clk);
    src = s; dst = d; nbytes = nb; go = 1'b1; abort = go_abort; ready = 1'b0;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    cyc = 0;
    all_fin = 1'b0;
    forever begin
      all_fin = 1'b1;
      for (int k = 0; k < NDut; k++) begin
        check_eq($sformatf("d%0d_done", k), done[k], exp_done_next[k]);
        check_eq($sformatf("d%0d_err_valid", k), err_valid[k], exp_done_next[k] && exp_err[k]);
        if (exp_done_next[k] && exp_err[k]) begin
          check_eq($sformatf("d%0d_err_addr", k), err_addr[k], exp_err_addr[k]);
          check_eq($sformatf("d%0d_err_src", k), err_src[k], 2);
        end
        if (exp_done_next[k]) finished[k] = 1'b1;
        exp_done_next[k] = 1'b0;
        all_fin = all_fin && finished[k];
      end
      if (all_fin || cyc >= 20000) break;

      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = (cyc >= 5);
      endcase
      stray_ok = 1'b1;
      for (int k = 0; k < NDut; k++) if (exp_addr[k].size() < 2) stray_ok = 1'b0;
      go = (mode == 1) && (cyc == 3) && stray_ok;
      if (go) begin
        src = ~s; dst = ~d; nbytes = 32'd8;
      end
      abort = do_abort && (cyc == 2);

      for (int k = 0; k < NDut; k++) begin
        exp_v = (exp_addr[k].size() != 0);
        if (abort && exp_v) begin
          while (exp_addr[k].size() > 1) begin
            void'(exp_addr[k].pop_back());
            void'(exp_alen[k].pop_back());
          end
        end
        check_eq($sformatf("d%0d_valid", k), req_valid[k], exp_v);
        if (exp_v) begin
          check_eq($sformatf("d%0d_addr", k), req_addr[k], exp_addr[k][0]);
          check_eq($sformatf("d%0d_alen", k), req_alen[k], exp_alen[k][0]);
          check_eq($sformatf("d%0d_size", k), req_size[k], 3);
          check_eq($sformatf("d%0d_strb", k), req_strb[k], 8'hFF);
          if (ready) begin
            void'(exp_addr[k].pop_front());
            void'(exp_alen[k].pop_front());
            if (exp_addr[k].size() == 0) exp_done_next[k] = 1'b1;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    go = 1'b0; abort = 1'b0; ready = 1'b0;
    check_eq("all_done_in_budget", all_fin, 1);
  endtask

  logic [31:0] rs, rd, rn;
  int          rmode;
  bit          rab;

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; ready = 1'b0;
    src = '0; dst = '0; nbytes = '0;
    #1;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Abort while idle has no effect on the next descriptor.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;

    run_desc(32'h0000_1000, 32'h0000_2000, 32'd64,   0, 1'b0, 1'b0);
    run_desc(32'h0000_0FF0, 32'h0000_2000, 32'd48,   0, 1'b0, 1'b0);
    run_desc(32'h0000_1000, 32'h0000_2000, 32'd4096, 0, 1'b0, 1'b0);
    run_desc(32'h0000_1004, 32'h0000_2000, 32'd16,   0, 1'b0, 1'b0);
    run_desc(32'h0000_1000, 32'h0000_2004, 32'd64,   2, 1'b1, 1'b0);
    run_desc(32'h0000_1000, 32'h0000_2000, 32'd0,    0, 1'b0, 1'b0);
    run_desc(32'h0000_1000, 32'h0000_2000, 32'd20,   0, 1'b0, 1'b0);
    run_desc(32'h0000_1000, 32'h0000_2FF0, 32'd64,   1, 1'b0, 1'b1);
    run_desc(32'hFFFF_FF00, 32'hFFFF_F800, 32'd2560, 1, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rs = $urandom();
      rd = $urandom();
      if ($urandom_range(0, 1) == 1) rs[11:8] = 4'hF;
      if ($urandom_range(0, 1) == 1) rd[11:8] = 4'hF;
      rs[2:0] = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'd0;
      rd[2:0] = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'd0;
      rn = 32'($urandom_range(0, 300)) * 8;
      if ($urandom_range(0, 9) == 0) rn = rn + 4;
      rmode = int'($urandom_range(1, 2));
      rab   = (rmode == 2) && ($urandom_range(0, 1) == 1);
      run_desc(rs, rd, rn, rmode, rab, 1'b0);
    end

    // Reset in the middle of a long transfer.
    @(negedge clk);
    src = 32'h0000_3000; dst = 32'h0000_4000; nbytes = 32'd4096; go = 1'b1; ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_valid", req_valid[2], 1);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NDut; k++) begin
        check_eq($sformatf("post_rst_d%0d_done", k), done[k], 0);
        check_eq($sformatf("post_rst_d%0d_errv", k), err_valid[k], 0);
        check_eq($sformatf("post_rst_d%0d_valid", k), req_valid[k], 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
